data_resp_checker: RTL

- Synthesizable response checker on the output side of the TOP data path. It is the consumer of DATA_O, where the stimulus side is the producer of DATA_I.
- The stimulus side presents each expected byte at the cycle it drives the DUT input.
- The checker delays that expectation by the DUT pipeline latency, compares it against the observed DUT output, and counts mismatches.
- It reports pass/fail and the first failing sample, so regressions can self-check in hardware or in simulation without $display inspection.

---
 rtl/data_chk_pkg.sv | 17 +
 rtl/data_delay_pipe.sv | 35 +++
 rtl/data_resp_checker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/data_chk_pkg.sv
// Shared constants for the data response checker and its stimulus-side partner.
// State encoding plus the default bus width, latency and run length.
package data_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_LATENCY = 3;
  localparam int unsigned DEF_COUNT   = 16;
  localparam int unsigned DEF_CNT_W   = 8;

endpackage

// File: rtl/data_delay_pipe.sv
// Valid+data shift register: a sample entering at cycle t leaves at cycle t+P_LATENCY.
// Also used by the stimulus generator to align launches with DUT outputs.
module data_delay_pipe #(
  parameter int P_WIDTH   = 8,
  parameter int P_LATENCY = 3
) (
  input  logic               CLK_I,
  input  logic               RST_X,
  input  logic               vld_i,
  input  logic [P_WIDTH-1:0] data_i,
  output logic               vld_o,
  output logic [P_WIDTH-1:0] data_o
);

  logic [P_LATENCY-1:0] vld_q;
  logic [P_WIDTH-1:0]   data_q [P_LATENCY];

  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      vld_q <= '0;
      for (int i = 0; i < P_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int i = 1; i < P_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[P_LATENCY-1];
  assign data_o = data_q[P_LATENCY-1];

endmodule

// File: rtl/data_resp_checker.sv
// Compares DUT output against latency-aligned expectations over a run of P_COUNT samples,
// reporting a saturating error count, the first failing sample and a pass flag.
module data_resp_checker
  import data_chk_pkg::*;
#(
  parameter int P_WIDTH   = DEF_WIDTH,
  parameter int P_LATENCY = DEF_LATENCY,
  parameter int P_COUNT   = DEF_COUNT,
  parameter int P_CNT_W   = DEF_CNT_W
) (
  input  logic               CLK_I,
  input  logic               RST_X,
  input  logic               START_I,
  input  logic               EXP_VALID_I,
  input  logic [P_WIDTH-1:0] EXP_I,
  input  logic [P_WIDTH-1:0] DATA_I,
  output logic               BUSY_O,
  output logic               DONE_O,
  output logic               PASS_O,
  output logic [P_CNT_W-1:0] ERR_CNT_O,
  output logic [P_CNT_W-1:0] FIRST_ERR_IDX_O,
  output logic [P_WIDTH-1:0] FIRST_ERR_DATA_O
);

  localparam int SMP_W = $clog2(P_COUNT + 1);
  localparam logic [SMP_W-1:0] LAST = SMP_W'(P_COUNT);

  function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e             state_q, state_d;
  logic [SMP_W-1:0]   launch_cnt_q, launch_cnt_d;
  logic [SMP_W-1:0]   cmp_cnt_q, cmp_cnt_d;
  logic [P_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [P_CNT_W-1:0] first_idx_q, first_idx_d;
  logic [P_WIDTH-1:0] first_data_q, first_data_d;
  logic               pass_q, pass_d;

  logic               launch;
  logic               pipe_vld;
  logic [P_WIDTH-1:0] pipe_data;

  assign launch = EXP_VALID_I && (state_q == S_RUN);

  data_delay_pipe #(
    .P_WIDTH  (P_WIDTH),
    .P_LATENCY(P_LATENCY)
  ) u_pipe (
    .CLK_I (CLK_I),
    .RST_X (RST_X),
    .vld_i (launch),
    .data_i(EXP_I),
    .vld_o (pipe_vld),
    .data_o(pipe_data)
  );

  always_comb begin
    state_d      = state_q;
    launch_cnt_d = launch_cnt_q;
    cmp_cnt_d    = cmp_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_idx_d  = first_idx_q;
    first_data_d = first_data_q;
    pass_d       = pass_q;

    // Compare and launch bookkeeping run independently so they may coincide.
    if (pipe_vld) begin
      cmp_cnt_d = cmp_cnt_q + 1'b1;
      if (pipe_data != DATA_I) begin
        if (err_cnt_q == '0) begin
          first_idx_d  = P_CNT_W'(cmp_cnt_q);
          first_data_d = DATA_I;
        end
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end
    if (launch) launch_cnt_d = launch_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (START_I) begin
          state_d      = S_RUN;
          launch_cnt_d = '0;
          cmp_cnt_d    = '0;
          err_cnt_d    = '0;
          first_idx_d  = '0;
          first_data_d = '0;
          pass_d       = 1'b0;
        end
      end
      S_RUN: begin
        if (launch && (launch_cnt_d == LAST)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Post-increment values so the final compare is part of the verdict.
        if (cmp_cnt_d == LAST) begin
          state_d = S_DONE;
          pass_d  = (err_cnt_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= S_IDLE;
      launch_cnt_q <= '0;
      cmp_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      launch_cnt_q <= launch_cnt_d;
      cmp_cnt_q    <= cmp_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_idx_q  <= first_idx_d;
      first_data_q <= first_data_d;
      pass_q       <= pass_d;
    end
  end

  assign BUSY_O           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign DONE_O           = (state_q == S_DONE);
  assign PASS_O           = pass_q;
  assign ERR_CNT_O        = err_cnt_q;
  assign FIRST_ERR_IDX_O  = first_idx_q;
  assign FIRST_ERR_DATA_O = first_data_q;

endmodule
